stopwatch_controller: RTL

//  Run-control for the stopwatch: turns debounced button levels into start/stop, lap and clear

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/stopwatch_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int TIME_W     = DIGIT_W * NUM_DIGITS;

    localparam logic [DIGIT_W-1:0] H1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] H10_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] S1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] S10_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] M1_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] M10_MAX = 4'd5;

    localparam logic [TIME_W-1:0] TIME_MAX = 24'h595999;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the time chain, counting 0..MAX with combinational carry-out.
// Latency: digit updates on the edge after inc/clr; carry is same-cycle.
// Backpressure: none, inc is consumed unconditionally.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            // >= keeps the digit legal even if it somehow held an out-of-range code
            digit_d = (digit_q >= MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch run-control: button presses -> IDLE/RUNNING/PAUSED, gated 100 Hz BCD time chain, lap freeze (STOPWATCH_LAP_EN).
// Latency: one cycle from tick/press to time_bcd, state, lap and overflow outputs.
// Backpressure: none; ticks outside RUNNING are dropped, presses act once per rising level.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_HZ           = 100,
    parameter int ROLLOVER_SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_start_stop,
    input  logic              btn_lap,
    input  logic              btn_clear,
    output logic [TIME_W-1:0] time_bcd,
    output logic [TIME_W-1:0] display_bcd,
    output logic              running,
    output logic              lap_active,
    output logic              overflow
);

    if (TICK_HZ != 100) begin : g_tick_hz_check
        $error("stopwatch_controller: TICK_HZ must be 100");
    end

    state_e state_q, state_d;
    logic   ss_q, lap_btn_q, clr_btn_q;
    logic   press_ss, press_lap, press_clr;
    logic   count_en, at_max, do_clear, inc_h1;
    logic   overflow_q, overflow_d;

    logic [DIGIT_W-1:0] h1, h10, s1, s10, m1, m10;
    logic c_h1, c_h10, c_s1, c_s10, c_m1, unused_m10_carry;

    assign press_ss  = btn_start_stop & ~ss_q;
    assign press_lap = btn_lap & ~lap_btn_q;
    assign press_clr = btn_clear & ~clr_btn_q;

    assign time_bcd   = {m10, m1, s10, s1, h10, h1};
    assign count_en   = (state_q == RUNNING) & tick;
    assign at_max     = (time_bcd == TIME_MAX);
    assign overflow_d = count_en & at_max;
    // Saturating build holds 59:59.99 by not feeding the final tick into the chain
    assign inc_h1     = count_en & ~((ROLLOVER_SATURATE != 0) & at_max);

    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_ss) state_d = RUNNING;
            end
            RUNNING: begin
                if ((ROLLOVER_SATURATE != 0) && overflow_d) state_d = PAUSED;
                else if (press_ss)                          state_d = PAUSED;
            end
            PAUSED: begin
                if (press_clr) begin
                    state_d  = IDLE;
                    do_clear = 1'b1;
                end else if (press_ss) begin
                    state_d = RUNNING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ss_q       <= 1'b1;
            lap_btn_q  <= 1'b1;
            clr_btn_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_q       <= btn_start_stop;
            lap_btn_q  <= btn_lap;
            clr_btn_q  <= btn_clear;
            overflow_q <= overflow_d;
        end
    end

    bcd_digit #(.MAX(H1_MAX))  u_h1  (.clk(clk), .rst(rst), .clr(do_clear), .inc(inc_h1), .digit(h1),  .carry(c_h1));
    bcd_digit #(.MAX(H10_MAX)) u_h10 (.clk(clk), .rst(rst), .clr(do_clear), .inc(c_h1),   .digit(h10), .carry(c_h10));
    bcd_digit #(.MAX(S1_MAX))  u_s1  (.clk(clk), .rst(rst), .clr(do_clear), .inc(c_h10),  .digit(s1),  .carry(c_s1));
    bcd_digit #(.MAX(S10_MAX)) u_s10 (.clk(clk), .rst(rst), .clr(do_clear), .inc(c_s1),   .digit(s10), .carry(c_s10));
    bcd_digit #(.MAX(M1_MAX))  u_m1  (.clk(clk), .rst(rst), .clr(do_clear), .inc(c_s10),  .digit(m1),  .carry(c_m1));
    bcd_digit #(.MAX(M10_MAX)) u_m10 (.clk(clk), .rst(rst), .clr(do_clear), .inc(c_m1),   .digit(m10), .carry(unused_m10_carry));

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] lap_q, lap_d;
    logic              lap_active_q, lap_active_d;

    always_comb begin
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        if (press_lap && state_q == RUNNING) begin
            if (!lap_active_q) begin
                lap_d        = time_bcd;
                lap_active_d = 1'b1;
            end else begin
                lap_active_d = 1'b0;
            end
        end else if (press_lap && state_q == PAUSED) begin
            lap_active_d = 1'b0;
        end
        if (do_clear) lap_active_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
        end else begin
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign lap_active  = lap_active_q;
    assign display_bcd = lap_active_q ? lap_q : time_bcd;
`else
    logic unused_press_lap;
    assign unused_press_lap = press_lap;
    assign lap_active       = 1'b0;
    assign display_bcd      = time_bcd;
`endif

    assign running  = (state_q == RUNNING);
    assign overflow = overflow_q;

endmodule
